// File: rtl/cfg_int.sv
// Host/Wishbone channel configuration register block for decoder and encoder cores.
// Optional CFG_INT_WB_ERR_EN: unmapped Wishbone accesses return err instead of ack.
module cfg_int_wb (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          adr_i,
  input  logic                 we_i,
  input  logic [31:0]          dat_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic [31:0][2:0]     ch_i,
  input  logic                 done_i,
  output logic [31:0]          dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rdy_o
);

  logic [31:0] dat_q, dat_d, rd_val;
  logic        ack_q, ack_d;
  logic        rdy_q, rdy_d;
  logic        req, is_ch, is_done, is_rdy;
  logic        unused;

  assign is_ch   = ~adr_i[7];
  assign is_done = adr_i[7:2] == 6'b100000;
  assign is_rdy  = adr_i[7:0] == 8'h84;
  assign unused  = ^{adr_i[31:8], dat_i[31:1]};

`ifdef CFG_INT_WB_ERR_EN
  logic err_q, err_d;
  logic hit;
  assign hit   = is_ch | is_done | is_rdy;
  assign req   = cyc_i & stb_i & ~ack_q & ~err_q;
  assign err_o = err_q;
`else
  assign req   = cyc_i & stb_i & ~ack_q;
  assign err_o = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_ch:   rd_val = {29'b0, ch_i[adr_i[6:2]]};
      is_done: rd_val = {31'b0, done_i};
      is_rdy:  rd_val = {31'b0, rdy_q};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    dat_d = dat_q;
    rdy_d = rdy_q;
`ifdef CFG_INT_WB_ERR_EN
    err_d = 1'b0;
`endif
    // ready write does not wait for ack
    if (cyc_i & stb_i & we_i & is_rdy)
      rdy_d = dat_i[0];
    if (req) begin
`ifdef CFG_INT_WB_ERR_EN
      if (hit) begin
        ack_d = 1'b1;
        dat_d = rd_val;
      end else begin
        err_d = 1'b1;
      end
`else
      ack_d = 1'b1;
      dat_d = rd_val;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
`ifdef CFG_INT_WB_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      dat_q <= dat_d;
      ack_q <= ack_d;
      rdy_q <= rdy_d;
`ifdef CFG_INT_WB_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign rdy_o = rdy_q;

endmodule

module cfg_int (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  input  logic        cs,
  input  logic        ws,
  input  logic        rs,
  input  logic [7:0]  w_data,
  input  logic [6:0]  addrs,
  output logic [7:0]  r_data,
  input  logic [31:0] i_wb_adr_e,
  input  logic [3:0]  i_wb_sel_e,
  input  logic        i_wb_we_e,
  input  logic [31:0] i_wb_dat_e,
  input  logic        i_wb_cyc_e,
  input  logic        i_wb_stb_e,
  output logic [31:0] o_wb_dat_e,
  output logic        o_wb_ack_e,
  output logic        o_wb_err_e,
  input  logic [31:0] i_wb_adr_d,
  input  logic [3:0]  i_wb_sel_d,
  input  logic        i_wb_we_d,
  input  logic [31:0] i_wb_dat_d,
  input  logic        i_wb_cyc_d,
  input  logic        i_wb_stb_d,
  output logic [31:0] o_wb_dat_d,
  output logic        o_wb_ack_d,
  output logic        o_wb_err_d
);

  localparam int NCH = 32;
  localparam int CHW = 3;

  logic [NCH-1:0][CHW-1:0] dch_q, dch_d;
  logic [NCH-1:0][CHW-1:0] ech_q, ech_d;
  logic [NCH-1:0]          dmask_q, dmask_d;
  logic [NCH-1:0]          emask_q, emask_d;
  logic                    ddone_q, ddone_d;
  logic                    edone_q, edone_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    drdy, erdy;
  logic                    hwr, hrd;
  logic                    unused;

  assign hwr = cs & ws & ~addrs[6];
  assign hrd = cs & rs;

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign unused = ^{scan_in0, scan_in1, scan_in2, scan_in3,
                    scan_in4, scan_enable, test_mode,
                    w_data[7:3], i_wb_sel_e, i_wb_sel_d};

  always_comb begin
    dch_d   = dch_q;
    ech_d   = ech_q;
    dmask_d = dmask_q;
    emask_d = emask_q;
    if (hwr) begin
      if (addrs[5]) begin
        ech_d[addrs[4:0]]   = w_data[2:0];
        emask_d[addrs[4:0]] = 1'b1;
      end else begin
        dch_d[addrs[4:0]]   = w_data[2:0];
        dmask_d[addrs[4:0]] = 1'b1;
      end
    end
    // done tracks the next mask so it rises with the last write
    ddone_d = ddone_q | (&dmask_d);
    edone_d = edone_q | (&emask_d);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (hrd) begin
      unique case (1'b1)
        ~addrs[6]:
          rdata_d = {5'b0, addrs[5] ? ech_q[addrs[4:0]]
                                    : dch_q[addrs[4:0]]};
        addrs == 7'h40: rdata_d = {7'b0, drdy};
        addrs == 7'h60: rdata_d = {7'b0, erdy};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dch_q   <= '0;
      ech_q   <= '0;
      dmask_q <= '0;
      emask_q <= '0;
      ddone_q <= 1'b0;
      edone_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      dch_q   <= dch_d;
      ech_q   <= ech_d;
      dmask_q <= dmask_d;
      emask_q <= emask_d;
      ddone_q <= ddone_d;
      edone_q <= edone_d;
      rdata_q <= rdata_d;
    end
  end

  assign r_data = rdata_q;

  cfg_int_wb u_wb_d (
    .clk    (clk),
    .reset  (reset),
    .adr_i  (i_wb_adr_d),
    .we_i   (i_wb_we_d),
    .dat_i  (i_wb_dat_d),
    .cyc_i  (i_wb_cyc_d),
    .stb_i  (i_wb_stb_d),
    .ch_i   (dch_q),
    .done_i (ddone_q),
    .dat_o  (o_wb_dat_d),
    .ack_o  (o_wb_ack_d),
    .err_o  (o_wb_err_d),
    .rdy_o  (drdy)
  );

  cfg_int_wb u_wb_e (
    .clk    (clk),
    .reset  (reset),
    .adr_i  (i_wb_adr_e),
    .we_i   (i_wb_we_e),
    .dat_i  (i_wb_dat_e),
    .cyc_i  (i_wb_cyc_e),
    .stb_i  (i_wb_stb_e),
    .ch_i   (ech_q),
    .done_i (edone_q),
    .dat_o  (o_wb_dat_e),
    .ack_o  (o_wb_ack_e),
    .err_o  (o_wb_err_e),
    .rdy_o  (erdy)
  );

endmodule

// File: tb/tb_cfg_int.sv
// Scoreboard bench for cfg_int: host port and both Wishbone ports.
// Honours CFG_INT_WB_ERR_EN for the unmapped-address check.
module tb_cfg_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_enable, test_mode;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic        cs, ws, rs;
  logic [7:0]  w_data;
  logic [6:0]  addrs;
  logic [7:0]  r_data;
  logic [31:0] i_wb_adr_e, i_wb_dat_e, o_wb_dat_e;
  logic [3:0]  i_wb_sel_e;
  logic        i_wb_we_e, i_wb_cyc_e, i_wb_stb_e;
  logic        o_wb_ack_e, o_wb_err_e;
  logic [31:0] i_wb_adr_d, i_wb_dat_d, o_wb_dat_d;
  logic [3:0]  i_wb_sel_d;
  logic        i_wb_we_d, i_wb_cyc_d, i_wb_stb_d;
  logic        o_wb_ack_d, o_wb_err_d;

  always #5 clk = ~clk;

  cfg_int dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .cs(cs), .ws(ws), .rs(rs), .w_data(w_data), .addrs(addrs),
    .r_data(r_data),
    .i_wb_adr_e(i_wb_adr_e), .i_wb_sel_e(i_wb_sel_e),
    .i_wb_we_e(i_wb_we_e), .i_wb_dat_e(i_wb_dat_e),
    .i_wb_cyc_e(i_wb_cyc_e), .i_wb_stb_e(i_wb_stb_e),
    .o_wb_dat_e(o_wb_dat_e), .o_wb_ack_e(o_wb_ack_e),
    .o_wb_err_e(o_wb_err_e),
    .i_wb_adr_d(i_wb_adr_d), .i_wb_sel_d(i_wb_sel_d),
    .i_wb_we_d(i_wb_we_d), .i_wb_dat_d(i_wb_dat_d),
    .i_wb_cyc_d(i_wb_cyc_d), .i_wb_stb_d(i_wb_stb_d),
    .o_wb_dat_d(o_wb_dat_d), .o_wb_ack_d(o_wb_ack_d),
    .o_wb_err_d(o_wb_err_d)
  );

  int          errs = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  m_ch[2][32];
  logic [31:0] m_mask[2];
  logic        m_rdy[2];
  logic [31:0] last_d;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) m_ch[c][i] = '0;
      m_mask[c] = '0;
      m_rdy[c]  = 1'b0;
    end
  endtask

  function automatic logic [7:0] m_host(input logic [6:0] a);
    if (!a[6]) return {5'b0, m_ch[a[5]][a[4:0]]};
    if (a == 7'h40) return {7'b0, m_rdy[0]};
    if (a == 7'h60) return {7'b0, m_rdy[1]};
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_wb(input bit c, input logic [31:0] a);
    if (!a[7]) return {29'b0, m_ch[c][a[6:2]]};
    if (a[7:2] == 6'b100000) return {31'b0, &m_mask[c]};
    if (a[7:0] == 8'h84) return {31'b0, m_rdy[c]};
    return '0;
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hdead_beef;
    return exp_q.pop_front();
  endfunction

  task automatic wb_drive(input bit c, input logic cy, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    if (c) begin
      i_wb_cyc_e = cy; i_wb_stb_e = cy; i_wb_we_e = we;
      i_wb_adr_e = a;  i_wb_dat_e = d;
    end else begin
      i_wb_cyc_d = cy; i_wb_stb_d = cy; i_wb_we_d = we;
      i_wb_adr_d = a;  i_wb_dat_d = d;
    end
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1; ws = 1; rs = 0; addrs = a; w_data = d;
    @(posedge clk); #1;
    if (!a[6]) begin
      m_ch[a[5]][a[4:0]]   = d[2:0];
      m_mask[a[5]][a[4:0]] = 1'b1;
    end
    @(negedge clk);
    cs = 0; ws = 0;
  endtask

  task automatic host_rd(input logic [6:0] a, input string tag);
    @(negedge clk);
    cs = 1; rs = 1; ws = 0; addrs = a;
    exp_q.push_back({24'b0, m_host(a)});
    @(posedge clk); #1;
    chk(tag, {24'b0, r_data}, pop_exp());
    @(negedge clk);
    cs = 0; rs = 0;
  endtask

  task automatic wb_acc(input bit c, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int   n;
    logic got;
    logic [31:0] e;
    n = 0; got = 0;
    if (!we) exp_q.push_back(m_wb(c, a));
    @(negedge clk);
    wb_drive(c, 1, we, a, d);
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      got = c ? o_wb_ack_e : o_wb_ack_d;
    end
    if (we && a[7:0] == 8'h84) m_rdy[c] = d[0];
    chk({tag, "_lat"}, n, 1);
    if (!we) begin
      e = pop_exp();
      chk(tag, c ? o_wb_dat_e : o_wb_dat_d, e);
      if (!c) last_d = e;
    end
    @(negedge clk);
    wb_drive(c, 0, 0, '0, '0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, c ? o_wb_ack_e : o_wb_ack_d}, 0);
  endtask

  initial begin
    reset = 1;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = '0;
    scan_enable = 0; test_mode = 0;
    cs = 0; ws = 0; rs = 0; w_data = 0; addrs = 0;
    i_wb_sel_e = 4'hf; i_wb_sel_d = 4'hf;
    wb_drive(0, 0, 0, '0, '0);
    wb_drive(1, 0, 0, '0, '0);
    m_clear();
    last_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", {24'b0, r_data}, 0);
    chk("rst_ack_d", {31'b0, o_wb_ack_d}, 0);
    chk("rst_dat_e", o_wb_dat_e, 0);
    chk("rst_err_d", {31'b0, o_wb_err_d}, 0);
    @(negedge clk);
    reset = 0;

    host_wr(7'h05, 8'h03);
    wb_acc(0, 0, 32'h14, 0, "d_ch5");
    chk("d_ch5_lit", o_wb_dat_d, 32'h3);
    host_wr(7'h3F, 8'h06);
    wb_acc(1, 0, 32'h7C, 0, "e_ch31");
    host_rd(7'h3F, "h_ch31");
    repeat (3) @(posedge clk);
    #1;
    chk("h_hold", {24'b0, r_data}, 32'h06);

    for (int i = 0; i < 16; i++) host_wr(7'(i), 8'(i + 1));
    wb_acc(0, 0, 32'h80, 0, "d_done16");
    for (int i = 16; i < 32; i++) host_wr(7'(i), 8'(i));
    wb_acc(0, 0, 32'h80, 0, "d_done32");
    chk("d_done32_lit", o_wb_dat_d, 32'h1);
    wb_acc(1, 0, 32'h80, 0, "e_done");

    wb_acc(1, 1, 32'h84, 32'h1, "e_rdy_wr");
    host_rd(7'h60, "h_rdy_e");
    host_rd(7'h40, "h_rdy_d0");
    wb_acc(0, 1, 32'h84, 32'h1, "d_rdy_wr");
    host_rd(7'h40, "h_rdy_d1");
    wb_acc(0, 0, 32'h84, 0, "d_rdy_rd");

    // host write and WB read of the same register in one cycle
    @(negedge clk);
    exp_q.push_back(m_wb(0, 32'h28));
    cs = 1; ws = 1; addrs = 7'h0A; w_data = 8'h07;
    wb_drive(0, 1, 0, 32'h28, 0);
    @(posedge clk); #1;
    chk("col_ack", {31'b0, o_wb_ack_d}, 1);
    chk("col_dat", o_wb_dat_d, pop_exp());
    m_ch[0][10] = 3'h7;
    m_mask[0][10] = 1'b1;
    @(negedge clk);
    cs = 0; ws = 0;
    wb_drive(0, 0, 0, '0, '0);
    wb_acc(0, 0, 32'h28, 0, "col_new");

    // host read of a ready flag while WB clears it
    @(negedge clk);
    exp_q.push_back({24'b0, m_host(7'h60)});
    cs = 1; rs = 1; addrs = 7'h60;
    wb_drive(1, 1, 1, 32'h84, 32'h0);
    @(posedge clk); #1;
    chk("rdy_col", {24'b0, r_data}, pop_exp());
    m_rdy[1] = 1'b0;
    @(negedge clk);
    cs = 0; rs = 0;
    wb_drive(1, 0, 0, '0, '0);
    host_rd(7'h60, "rdy_col_new");
    host_rd(7'h3F, "pre_rst_rd");

    // reset while a WB read is being acknowledged
    @(negedge clk);
    wb_drive(1, 1, 0, 32'h7C, 0);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("mid_rst_ack", {31'b0, o_wb_ack_e}, 0);
    chk("mid_rst_dat", o_wb_dat_e, 0);
    chk("mid_rst_rdata", {24'b0, r_data}, 0);
    wb_drive(1, 0, 0, '0, '0);
    @(negedge clk);
    reset = 0;
    m_clear();
    wb_acc(0, 0, 32'h80, 0, "rst_done_d");
    wb_acc(1, 0, 32'h7C, 0, "rst_ch_e");
    host_rd(7'h40, "rst_rdy_d");
    host_rd(7'h05, "rst_ch_d");

    for (int k = 0; k < 1000; k++) begin
      int op;
      op = $urandom_range(0, 4);
      if (op <= 1)
        host_wr(7'($urandom_range(0, 127)), 8'($urandom));
      else if (op == 2)
        host_rd(7'($urandom_range(0, 127)), "rnd_host");
      else if (op == 3)
        wb_acc(1'($urandom_range(0, 1)), 0,
               32'($urandom_range(0, 33) * 4), 0, "rnd_wb");
      else
        wb_acc(1'($urandom_range(0, 1)), 1, 32'h84,
               32'($urandom_range(0, 1)), "rnd_rdy");
    end

    wb_acc(0, 0, 32'h08, 0, "pre_unmapped");
`ifdef CFG_INT_WB_ERR_EN
    begin
      int   n;
      logic got;
      n = 0; got = 0;
      @(negedge clk);
      wb_drive(0, 1, 0, 32'h90, 0);
      for (int i = 0; i < 8 && !got; i++) begin
        @(posedge clk); #1;
        n++;
        got = o_wb_err_d | o_wb_ack_d;
      end
      chk("err_lat", n, 1);
      chk("err_pulse", {31'b0, o_wb_err_d}, 1);
      chk("err_noack", {31'b0, o_wb_ack_d}, 0);
      chk("err_dat", o_wb_dat_d, last_d);
      @(negedge clk);
      wb_drive(0, 0, 0, '0, '0);
      @(posedge clk); #1;
      chk("err_off", {31'b0, o_wb_err_d}, 0);
    end
`else
    wb_acc(0, 0, 32'h90, 0, "unmapped_rd");
    chk("unmapped_err", {31'b0, o_wb_err_d}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
